// File: rtl/sdram_bank_model_param.sv
// Cycle-accurate SDRAM bank model: per-bank open row, wrapped bursts, CAS-latency read pipe, byte masks.
// Optional protocol checker and sdram_proto_err port under `SDRAM_MODEL_PROTO_CHECK_EN.
module sdram_bank_model_param #(
   parameter  int DATA_W    = 33,
   parameter  int ADDR_W    = 11,
   parameter  int BANK_W    = 2,
   parameter  int ROW_W     = 4,
   parameter  int COL_W     = 4,
   parameter  int CAS_LAT   = 2,
   parameter  int BURST_LEN = 4,
   localparam int DQM_W     = (DATA_W + 7) / 8
) (
   input  logic              clk,
   input  logic              sys_rst_l,
   input  logic              sdram_cs_l,
   input  logic              sdram_ras_l,
   input  logic              sdram_cas_l,
   input  logic              sdram_wr_l,
   input  logic [BANK_W-1:0] sdram_bank,
   input  logic [ADDR_W-1:0] sdram_addx,
   input  logic [DQM_W-1:0]  sdram_dqm,
   input  logic [DATA_W-1:0] sdram_data_in,
   output logic [DATA_W-1:0] sdram_data_out,
   output logic              sdram_data_vld
`ifdef SDRAM_MODEL_PROTO_CHECK_EN
   ,
   output logic              sdram_proto_err
);
`else
);
`endif

   // state  | meaning
   // B_IDLE | no burst; beats only issue from a new READ/WRITE command
   // B_RD   | issuing read beats 1..BURST_LEN-1 into the CAS pipe
   // B_WR   | writing beats 1..BURST_LEN-1 from the data bus
   localparam int BANKS = 1 << BANK_W;
   localparam int LB    = $clog2(BURST_LEN);
   localparam int CNT_W = (LB > 0) ? LB : 1;
   localparam int IDX_W = BANK_W + ROW_W + COL_W;
   localparam int DEPTH = 1 << IDX_W;
   localparam logic [COL_W-1:0] BLK_MASK = COL_W'(BURST_LEN - 1);

   typedef enum logic [1:0] {B_IDLE, B_RD, B_WR} burst_t;

   burst_t             b_state_q, b_state_d;
   logic [CNT_W-1:0]   beat_q, beat_d;
   logic [BANK_W-1:0]  b_bank_q, b_bank_d;
   logic [ROW_W-1:0]   b_row_q, b_row_d;
   logic [COL_W-1:0]   b_col_q, b_col_d;
   logic [BANKS-1:0]   open_q, open_d;
   logic [ROW_W-1:0]   row_q [BANKS];
   logic [ROW_W-1:0]   row_d [BANKS];
   logic [DATA_W-1:0]  mem_q [DEPTH];
   logic [CAS_LAT-1:0] pv_q;
   logic [DATA_W-1:0]  pd_q [CAS_LAT];

   logic [3:0]         cmd;
   logic               is_act, is_rd, is_wr, is_pre, bank_open, start_rd, start_wr;
   logic               do_rd, do_wr;
   logic [BANK_W-1:0]  beat_bank;
   logic [ROW_W-1:0]   beat_row;
   logic [COL_W-1:0]   beat_col, beat_col_w;
   logic [CNT_W-1:0]   beat_k;
   logic [IDX_W-1:0]   beat_idx;
   logic [DATA_W-1:0]  lane_en, rd_word;
   logic               addx_unused;

   assign cmd       = {sdram_cs_l, sdram_ras_l, sdram_cas_l, sdram_wr_l};
   assign is_act    = (cmd == 4'b0011);
   assign is_rd     = (cmd == 4'b0101);
   assign is_wr     = (cmd == 4'b0100);
   assign is_pre    = (cmd == 4'b0010);
   assign bank_open = open_q[sdram_bank];
   assign start_rd  = is_rd && bank_open;
   assign start_wr  = is_wr && bank_open;
   assign addx_unused = ^sdram_addx;

   always_ff @(posedge clk) begin
      if (!sys_rst_l) begin
         b_state_q <= B_IDLE;
         beat_q    <= '0;
         b_bank_q  <= '0;
         b_row_q   <= '0;
         b_col_q   <= '0;
         open_q    <= '0;
         for (int i = 0; i < BANKS; i++) row_q[i] <= '0;
      end else begin
         b_state_q <= b_state_d;
         beat_q    <= beat_d;
         b_bank_q  <= b_bank_d;
         b_row_q   <= b_row_d;
         b_col_q   <= b_col_d;
         open_q    <= open_d;
         row_q     <= row_d;
      end
   end

   always_comb begin
      b_state_d = b_state_q;
      beat_d    = beat_q;
      b_bank_d  = b_bank_q;
      b_row_d   = b_row_q;
      b_col_d   = b_col_q;
      open_d    = open_q;
      row_d     = row_q;
      if (is_act) begin
         open_d[sdram_bank] = 1'b1;
         row_d[sdram_bank]  = sdram_addx[ROW_W-1:0];
      end
      if (is_pre) begin
         if (sdram_addx[ADDR_W-1]) open_d = '0;
         else                      open_d[sdram_bank] = 1'b0;
      end
      // A new accepted command always pre-empts the burst in flight
      if (start_rd || start_wr) begin
         b_bank_d  = sdram_bank;
         b_row_d   = row_q[sdram_bank];
         b_col_d   = sdram_addx[COL_W-1:0];
         beat_d    = CNT_W'(1);
         if (BURST_LEN == 1) b_state_d = B_IDLE;
         else                b_state_d = start_rd ? B_RD : B_WR;
      end else if (b_state_q != B_IDLE) begin
         if (beat_q == CNT_W'(BURST_LEN - 1)) begin
            b_state_d = B_IDLE;
            beat_d    = '0;
         end else begin
            beat_d = beat_q + CNT_W'(1);
         end
      end
   end

   always_comb begin
      do_rd     = (b_state_q == B_RD);
      do_wr     = (b_state_q == B_WR);
      beat_bank = b_bank_q;
      beat_row  = b_row_q;
      beat_col  = b_col_q;
      beat_k    = beat_q;
      if (start_rd || start_wr) begin
         do_rd     = start_rd;
         do_wr     = start_wr;
         beat_bank = sdram_bank;
         beat_row  = row_q[sdram_bank];
         beat_col  = sdram_addx[COL_W-1:0];
         beat_k    = '0;
      end
      if (!sys_rst_l) begin
         do_rd = 1'b0;
         do_wr = 1'b0;
      end
   end

   assign beat_col_w = (beat_col & ~BLK_MASK) | ((beat_col + COL_W'(beat_k)) & BLK_MASK);
   assign beat_idx   = {beat_bank, beat_row, beat_col_w};

   always_comb begin
      lane_en = '0;
      for (int b = 0; b < DATA_W; b++) lane_en[b] = ~sdram_dqm[b/8];
   end

   assign rd_word = mem_q[beat_idx] & lane_en;

   always_ff @(posedge clk) begin
      if (do_wr) mem_q[beat_idx] <= (mem_q[beat_idx] & ~lane_en) | (sdram_data_in & lane_en);
   end

   // Issue-edge data enters stage 0; the output register adds the last clock of latency
   always_ff @(posedge clk) begin
      if (!sys_rst_l) begin
         pv_q           <= '0;
         sdram_data_vld <= 1'b0;
         sdram_data_out <= '0;
         for (int i = 0; i < CAS_LAT; i++) pd_q[i] <= '0;
      end else begin
         pv_q[0] <= do_rd;
         pd_q[0] <= rd_word;
         for (int i = 1; i < CAS_LAT; i++) begin
            pv_q[i] <= pv_q[i-1];
            pd_q[i] <= pd_q[i-1];
         end
         sdram_data_vld <= pv_q[CAS_LAT-1];
         if (pv_q[CAS_LAT-1]) sdram_data_out <= pd_q[CAS_LAT-1];
      end
   end

`ifdef SDRAM_MODEL_PROTO_CHECK_EN
   logic is_nop, undef_cmd, proto_err_q;
   assign is_nop    = sdram_cs_l || (cmd == 4'b0111);
   assign undef_cmd = !(is_nop || is_act || is_rd || is_wr || is_pre);

   always_ff @(posedge clk) begin
      if (!sys_rst_l) proto_err_q <= 1'b0;
      else proto_err_q <= ((is_rd || is_wr) && !bank_open) || (is_act && bank_open) || undef_cmd;
   end
   assign sdram_proto_err = proto_err_q;
`endif

endmodule

// File: tb/tb_sdram_bank_model_param.sv
// Directed bench for sdram_bank_model_param (CAS_LAT=2, BURST_LEN=4, DATA_W=33).
// Inputs change and outputs are sampled on the falling edge; the model is exercised on rising edges.
module tb_sdram_bank_model_param;
   localparam logic [3:0] C_NOP = 4'b0111;
   localparam logic [3:0] C_DES = 4'b1111;
   localparam logic [3:0] C_ACT = 4'b0011;
   localparam logic [3:0] C_RD  = 4'b0101;
   localparam logic [3:0] C_WR  = 4'b0100;
   localparam logic [3:0] C_PRE = 4'b0010;

   logic        clk = 1'b0;
   logic        sys_rst_l;
   logic        cs_l, ras_l, cas_l, wr_l;
   logic [1:0]  bank;
   logic [10:0] addx;
   logic [4:0]  dqm;
   logic [32:0] din;
   logic [32:0] dout;
   logic        vld;
`ifdef SDRAM_MODEL_PROTO_CHECK_EN
   logic        perr;
`endif
   int total  = 0;
   int passed = 0;

   always #5 clk = ~clk;

   sdram_bank_model_param #(
      .DATA_W(33), .ADDR_W(11), .BANK_W(2), .ROW_W(4), .COL_W(4), .CAS_LAT(2), .BURST_LEN(4)
   ) dut (
      .clk(clk),
      .sys_rst_l(sys_rst_l),
      .sdram_cs_l(cs_l),
      .sdram_ras_l(ras_l),
      .sdram_cas_l(cas_l),
      .sdram_wr_l(wr_l),
      .sdram_bank(bank),
      .sdram_addx(addx),
      .sdram_dqm(dqm),
      .sdram_data_in(din),
      .sdram_data_out(dout),
      .sdram_data_vld(vld)
`ifdef SDRAM_MODEL_PROTO_CHECK_EN
      ,
      .sdram_proto_err(perr)
`endif
   );

   task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic set_cmd(input logic [3:0] c, input logic [1:0] b, input logic [10:0] a,
                          input logic [4:0] m, input logic [32:0] d);
      {cs_l, ras_l, cas_l, wr_l} = c;
      bank = b;
      addx = a;
      dqm  = m;
      din  = d;
   endtask

   task automatic chk_perr(input string tag, input logic exp);
`ifdef SDRAM_MODEL_PROTO_CHECK_EN
      chk(tag, {32'd0, perr}, {32'd0, exp});
`else
      if (tag.len() < 0 || exp === 1'bz) $display("unused %s", tag);
`endif
   endtask

   task automatic write_burst(input logic [1:0] b, input logic [3:0] col,
                              input logic [32:0] d0, input logic [32:0] d1,
                              input logic [32:0] d2, input logic [32:0] d3,
                              input logic [4:0] m0, input logic [4:0] m1,
                              input logic [4:0] m2, input logic [4:0] m3);
      set_cmd(C_WR, b, {7'd0, col}, m0, d0); tick();
      set_cmd(C_NOP, 2'd0, 11'd0, m1, d1); tick();
      set_cmd(C_NOP, 2'd0, 11'd0, m2, d2); tick();
      set_cmd(C_NOP, 2'd0, 11'd0, m3, d3); tick();
      set_cmd(C_NOP, 2'd0, 11'd0, 5'd0, 33'd0);
   endtask

   task automatic read_burst(input string tag, input logic [1:0] b, input logic [3:0] col,
                             input logic [4:0] m,
                             input logic [32:0] e0, input logic [32:0] e1,
                             input logic [32:0] e2, input logic [32:0] e3);
      logic [32:0] ex [4];
      ex[0] = e0; ex[1] = e1; ex[2] = e2; ex[3] = e3;
      set_cmd(C_RD, b, {7'd0, col}, m, 33'd0); tick();
      chk({tag, "_lat1_vld"}, {32'd0, vld}, 33'd0);
      set_cmd(C_DES, 2'd0, 11'd0, m, 33'd0); tick();
      chk({tag, "_lat2_vld"}, {32'd0, vld}, 33'd0);
      tick();
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("%s_beat%0d_vld", tag, k), {32'd0, vld}, 33'd1);
         chk($sformatf("%s_beat%0d_data", tag, k), dout, ex[k]);
         tick();
      end
      chk({tag, "_end_vld"}, {32'd0, vld}, 33'd0);
      chk({tag, "_hold_data"}, dout, ex[3]);
      set_cmd(C_NOP, 2'd0, 11'd0, 5'd0, 33'd0);
   endtask

   initial begin
      logic [32:0] irq_exp [5];
      sys_rst_l = 1'b0;
      set_cmd(C_NOP, 2'd0, 11'd0, 5'd0, 33'd0);
      tick(); tick();
      chk("rst_vld", {32'd0, vld}, 33'd0);
      chk("rst_data", dout, 33'd0);
      chk_perr("rst_perr", 1'b0);
      sys_rst_l = 1'b1;

      // 1: write/read bank 0 row 1 col 4..7
      set_cmd(C_ACT, 2'd0, 11'd1, 5'd0, 33'd0); tick();
      chk_perr("act_b0_perr", 1'b0);
      write_burst(2'd0, 4'd4, 33'h0A, 33'h0B, 33'h0C, 33'h0D, 5'd0, 5'd0, 5'd0, 5'd0);
      read_burst("t1", 2'd0, 4'd4, 5'd0, 33'h0A, 33'h0B, 33'h0C, 33'h0D);

      // 2: wrapped order within the aligned block
      read_burst("t2", 2'd0, 4'd6, 5'd0, 33'h0C, 33'h0D, 33'h0A, 33'h0B);

      // READ interrupted by READ one edge later: issued beat 0 still emerges
      irq_exp[0] = 33'h0A; irq_exp[1] = 33'h0C; irq_exp[2] = 33'h0D;
      irq_exp[3] = 33'h0A; irq_exp[4] = 33'h0B;
      set_cmd(C_RD, 2'd0, 11'd4, 5'd0, 33'd0); tick();
      set_cmd(C_RD, 2'd0, 11'd6, 5'd0, 33'd0); tick();
      set_cmd(C_NOP, 2'd0, 11'd0, 5'd0, 33'd0); tick();
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("irq_beat%0d_vld", i), {32'd0, vld}, 33'd1);
         chk($sformatf("irq_beat%0d_data", i), dout, irq_exp[i]);
         tick();
      end
      chk("irq_end_vld", {32'd0, vld}, 33'd0);

      // 3: byte masks on write and read
      write_burst(2'd0, 4'd8, 33'd0, 33'd0, 33'd0, 33'd0, 5'd0, 5'd0, 5'd0, 5'd0);
      write_burst(2'd0, 4'd8, 33'h1_FFFF_FFFF, 33'h1_2345_6789, 33'h1_FFFF_FFFF, 33'h1_FFFF_FFFF,
                  5'b00101, 5'b00000, 5'b11111, 5'b11111);
      read_burst("t3w", 2'd0, 4'd8, 5'd0, 33'h1_FF00_FF00, 33'h1_2345_6789, 33'd0, 33'd0);
      read_burst("t3r", 2'd0, 4'd8, 5'b00001, 33'h1_FF00_FF00, 33'h1_2345_6700, 33'd0, 33'd0);

      // 4: READ to never-activated bank 2
      set_cmd(C_RD, 2'd2, 11'd0, 5'd0, 33'd0); tick();
      chk_perr("t4_perr_hi", 1'b1);
      set_cmd(C_NOP, 2'd0, 11'd0, 5'd0, 33'd0); tick();
      chk_perr("t4_perr_lo", 1'b0);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("t4_novld%0d", i), {32'd0, vld}, 33'd0);
         tick();
      end

      // 5: re-ACTIVE to row 3, PRECHARGE all, ignored WRITE/READ, then row 3 readback
      set_cmd(C_ACT, 2'd0, 11'd3, 5'd0, 33'd0); tick();
      chk_perr("t5_reopen_perr", 1'b1);
      write_burst(2'd0, 4'd0, 33'h30, 33'h31, 33'h32, 33'h33, 5'd0, 5'd0, 5'd0, 5'd0);
      set_cmd(C_PRE, 2'd1, 11'h400, 5'd0, 33'd0); tick();
      chk_perr("t5_pre_perr", 1'b0);
      set_cmd(C_WR, 2'd0, 11'd0, 5'd0, 33'h1_5555_5555); tick();
      chk_perr("t5_idlewr_perr", 1'b1);
      set_cmd(C_NOP, 2'd0, 11'd0, 5'd0, 33'h1_5555_5555); tick(); tick(); tick();
      set_cmd(C_RD, 2'd0, 11'd0, 5'd0, 33'd0); tick();
      chk_perr("t5_idlerd_perr", 1'b1);
      set_cmd(C_NOP, 2'd0, 11'd0, 5'd0, 33'd0);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("t5_novld%0d", i), {32'd0, vld}, 33'd0);
         tick();
      end
      set_cmd(4'b0001, 2'd0, 11'd0, 5'd0, 33'd0); tick();
      chk_perr("t5_undef_perr", 1'b1);
      set_cmd(C_ACT, 2'd0, 11'd3, 5'd0, 33'd0); tick();
      chk_perr("t5_act_perr", 1'b0);
      read_burst("t5", 2'd0, 4'd0, 5'd0, 33'h30, 33'h31, 33'h32, 33'h33);

      // 6: reset in the middle of a read burst
      set_cmd(C_ACT, 2'd0, 11'd1, 5'd0, 33'd0); tick();
      set_cmd(C_RD, 2'd0, 11'd4, 5'd0, 33'd0); tick();
      set_cmd(C_NOP, 2'd0, 11'd0, 5'd0, 33'd0); tick(); tick();
      chk("t6_pre_vld", {32'd0, vld}, 33'd1);
      chk("t6_pre_data", dout, 33'h0A);
      sys_rst_l = 1'b0; tick();
      chk("t6_rst_vld", {32'd0, vld}, 33'd0);
      chk("t6_rst_data", dout, 33'd0);
      sys_rst_l = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk($sformatf("t6_trail%0d_vld", i), {32'd0, vld}, 33'd0);
         chk($sformatf("t6_trail%0d_data", i), dout, 33'd0);
      end
      set_cmd(C_RD, 2'd0, 11'd4, 5'd0, 33'd0); tick();
      chk_perr("t6_closed_perr", 1'b1);
      set_cmd(C_ACT, 2'd0, 11'd1, 5'd0, 33'd0); tick();
      chk("t6_closed_novld", {32'd0, vld}, 33'd0);
      read_burst("t6", 2'd0, 4'd4, 5'd0, 33'h0A, 33'h0B, 33'h0C, 33'h0D);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
